// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel coordinates, line/frame measurements and lock status from an HS/VS stream.
// Define VGA_SYNC_DEC_BLANK_CHECK_EN to also check blank against the recovered active window while locked.
module vga_sync_decoder #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int H_OFFSET    = 144,
    parameter int V_OFFSET    = 34,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       pix_ce,
    input  logic       hs,
    input  logic       vs,
    input  logic       blank,
    output logic [9:0] RxX,
    output logic [9:0] RxY,
    output logic       rx_valid,
    output logic       locked,
    output logic       frame_start,
    output logic [9:0] line_len,
    output logic [9:0] frame_lines,
    output logic       err
);
    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    localparam logic [9:0] HT   = 10'(H_TOTAL);
    localparam logic [9:0] VT   = 10'(V_TOTAL);
    localparam logic [9:0] HO   = 10'(H_OFFSET);
    localparam logic [9:0] HE   = 10'(H_OFFSET + H_ACTIVE);
    localparam logic [9:0] VO   = 10'(V_OFFSET);
    localparam logic [9:0] VE   = 10'(V_OFFSET + V_ACTIVE);
    localparam logic [9:0] MAXC = 10'd1023;
    localparam logic [2:0] LF   = 3'(LOCK_FRAMES);

    state_t     state_q, state_d;
    logic       hs_q, hs_d, vs_q, vs_d, vs_pend_q, vs_pend_d;
    logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [9:0] rxx_q, rxx_d, rxy_q, rxy_d;
    logic [9:0] line_len_q, line_len_d, frame_lines_q, frame_lines_d;
    logic [2:0] good_q, good_d;
    logic       rx_valid_q, rx_valid_d, locked_q, locked_d;
    logic       frame_start_q, frame_start_d, err_q, err_d;
    logic       hs_fall, boundary, line_bad, frame_bad, win, bad;

`ifndef VGA_SYNC_DEC_BLANK_CHECK_EN
    logic unused_blank;
    assign unused_blank = blank;
`endif

    // A frame boundary is the first HS fall after a VS fall has been seen.
    assign hs_fall   = pix_ce & hs_q & ~hs;
    assign boundary  = hs_fall & vs_pend_q;
    assign line_bad  = hs_fall & (hcnt_q + 10'd1 != HT);
    assign frame_bad = boundary & (vcnt_q + 10'd1 != VT);

    always_comb begin
        state_d       = state_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        vs_pend_d     = vs_pend_q;
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        rxx_d         = rxx_q;
        rxy_d         = rxy_q;
        line_len_d    = line_len_q;
        frame_lines_d = frame_lines_q;
        good_d        = good_q;
        rx_valid_d    = rx_valid_q;
        locked_d      = locked_q;
        frame_start_d = 1'b0;
        err_d         = 1'b0;
        win           = 1'b0;
        bad           = 1'b0;
        if (pix_ce) begin
            hs_d      = hs;
            vs_d      = vs;
            vs_pend_d = (vs_q & ~vs) | (vs_pend_q & ~hs_fall);
            if (hs_fall) begin
                line_len_d    = hcnt_q + 10'd1;
                hcnt_d        = '0;
                vcnt_d        = boundary ? '0 : (vcnt_q == MAXC ? MAXC : vcnt_q + 10'd1);
                frame_lines_d = boundary ? vcnt_q + 10'd1 : frame_lines_q;
            end else begin
                hcnt_d = (hcnt_q == MAXC) ? MAXC : hcnt_q + 10'd1;
            end
            frame_start_d = boundary;
            win = (hcnt_d >= HO) && (hcnt_d < HE) && (vcnt_d >= VO) && (vcnt_d < VE);
            case (state_q)
                SEARCH: begin
                    if (boundary) begin
                        state_d = ACQUIRE;
                        good_d  = '0;
                    end
                end
                ACQUIRE: begin
                    if (line_bad | frame_bad) begin
                        err_d   = 1'b1;
                        state_d = SEARCH;
                    end else if (boundary) begin
                        good_d = good_q + 3'd1;
                        if (good_q + 3'd1 == LF) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    bad = line_bad | frame_bad | (hcnt_d == MAXC);
`ifdef VGA_SYNC_DEC_BLANK_CHECK_EN
                    bad = bad | (blank != win);
`endif
                    if (bad) begin
                        err_d    = 1'b1;
                        locked_d = 1'b0;
                        state_d  = SEARCH;
                    end
                end
                default: state_d = SEARCH;
            endcase
            rxx_d      = win ? hcnt_d - HO : '0;
            rxy_d      = win ? vcnt_d - VO : '0;
            rx_valid_d = locked_d & win;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= SEARCH;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            vs_pend_q     <= 1'b0;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            rxx_q         <= '0;
            rxy_q         <= '0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            good_q        <= '0;
            rx_valid_q    <= 1'b0;
            locked_q      <= 1'b0;
            frame_start_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            vs_pend_q     <= vs_pend_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            rxx_q         <= rxx_d;
            rxy_q         <= rxy_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            good_q        <= good_d;
            rx_valid_q    <= rx_valid_d;
            locked_q      <= locked_d;
            frame_start_q <= frame_start_d;
            err_q         <= err_d;
        end
    end

    assign RxX         = rxx_q;
    assign RxY         = rxy_q;
    assign rx_valid    = rx_valid_q;
    assign locked      = locked_q;
    assign frame_start = frame_start_q;
    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;
    assign err         = err_q;
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: directed tests on a scaled 40x12 raster (pix_ce every 2nd clock).
// Blank-check expectations follow VGA_SYNC_DEC_BLANK_CHECK_EN.
module tb_vga_sync_decoder;
    localparam int HT = 40, VT = 12, HA = 20, VA = 6, HO = 12, VO = 3;

    logic       clk = 1'b0, rst_n = 1'b0, pix_ce = 1'b0, hs = 1'b1, vs = 1'b1, blank = 1'b0;
    logic [9:0] rx_x, rx_y, line_len, frame_lines;
    logic       rx_valid, locked, frame_start, err;

    int         checks = 0, fails = 0;
    int         short_l = -1, blank_l = -1, blank_p = -1;
    int         pix_n, fs_n, err_n, err_pix;
    logic       lock_fs [16];
    logic [9:0] err_ll, err_fl, err_x, err_y, first_x, first_y, last_x, last_y;
    logic       err_lk, err_rv, lock_seen, got_rv;

    always #10 clk = ~clk;

    vga_sync_decoder #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA),
        .H_OFFSET(HO), .V_OFFSET(VO), .LOCK_FRAMES(2)
    ) dut (
        .Clk(clk), .Reset_n(rst_n), .pix_ce(pix_ce), .hs(hs), .vs(vs), .blank(blank),
        .RxX(rx_x), .RxY(rx_y), .rx_valid(rx_valid), .locked(locked),
        .frame_start(frame_start), .line_len(line_len), .frame_lines(frame_lines), .err(err)
    );

    task automatic clear_obs();
        pix_n = 0; fs_n = 0; err_n = 0; err_pix = -1;
        lock_seen = 1'b0; got_rv = 1'b0;
        err_ll = '0; err_fl = '0; err_x = '0; err_y = '0; err_lk = 1'b1; err_rv = 1'b1;
        first_x = '1; first_y = '1; last_x = '1; last_y = '1;
    endtask

    // One pixel: drive on a falling edge, sampled at the next rising edge, observed a half cycle later.
    task automatic pix(input logic h, input logic v, input logic b);
        @(negedge clk);
        hs = h; vs = v; blank = b; pix_ce = 1'b1;
        @(negedge clk);
        pix_ce = 1'b0;
        pix_n++;
        if (frame_start) begin
            if (fs_n < 16) lock_fs[fs_n] = locked;
            fs_n++;
        end
        if (err) begin
            err_n++; err_pix = pix_n; err_ll = line_len; err_fl = frame_lines;
            err_lk = locked; err_rv = rx_valid; err_x = rx_x; err_y = rx_y;
        end
        if (locked) lock_seen = 1'b1;
        if (rx_valid) begin
            if (!got_rv) begin first_x = rx_x; first_y = rx_y; got_rv = 1'b1; end
            last_x = rx_x; last_y = rx_y;
        end
    endtask

    task automatic send_line(input int l, input int nl);
        int len;
        len = (l == short_l) ? HT - 1 : HT;
        for (int p = 0; p < len; p++)
            pix(p >= 4, !(l == nl - 1 && p >= 20),
                (p >= HO && p < HO + HA && l >= VO && l < VO + VA) && !(l == blank_l && p == blank_p));
    endtask

    task automatic send_frame(input int nl, input int from);
        for (int l = from; l < nl; l++) send_line(l, nl);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({locked, rx_valid, err, frame_start} !== 4'b0) begin
            fails++; $display("FAIL reset_flags: got %b want 0000", {locked, rx_valid, err, frame_start});
        end
        checks++;
        if ({rx_x, rx_y, line_len, frame_lines} !== 40'd0) begin
            fails++; $display("FAIL reset_counts: got %h want 0", {rx_x, rx_y, line_len, frame_lines});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_nominal();
        clear_obs();
        send_frame(VT, 5);
        repeat (3) send_frame(VT, 0);
        checks++; if (fs_n !== 3) begin fails++; $display("FAIL nom_fs: got %0d want 3", fs_n); end
        checks++; if ({lock_fs[0], lock_fs[1], lock_fs[2]} !== 3'b001) begin
            fails++; $display("FAIL nom_lock_seq: got %b want 001", {lock_fs[0], lock_fs[1], lock_fs[2]}); end
        checks++; if (locked !== 1'b1) begin fails++; $display("FAIL nom_locked: got %b want 1", locked); end
        checks++; if (line_len !== 10'd40) begin fails++; $display("FAIL nom_line_len: got %0d want 40", line_len); end
        checks++; if (frame_lines !== 10'd12) begin fails++; $display("FAIL nom_frame_lines: got %0d want 12", frame_lines); end
        checks++; if ({first_x, first_y} !== {10'd0, 10'd0}) begin
            fails++; $display("FAIL nom_first_xy: got %0d,%0d want 0,0", first_x, first_y); end
        checks++; if ({last_x, last_y} !== {10'd19, 10'd5}) begin
            fails++; $display("FAIL nom_last_xy: got %0d,%0d want 19,5", last_x, last_y); end
        checks++; if (err_n !== 0) begin fails++; $display("FAIL nom_err: got %0d want 0", err_n); end
        checks++; if ({rx_valid, rx_x, rx_y} !== 21'd0) begin
            fails++; $display("FAIL nom_outside: got %b/%0d/%0d want 0/0/0", rx_valid, rx_x, rx_y); end
    endtask

    task automatic test_short_line();
        clear_obs();
        short_l = 5;
        send_frame(VT, 0);
        short_l = -1;
        repeat (3) send_frame(VT, 0);
        checks++; if (err_n !== 1) begin fails++; $display("FAIL short_err: got %0d want 1", err_n); end
        checks++; if (err_ll !== 10'd39) begin fails++; $display("FAIL short_line_len: got %0d want 39", err_ll); end
        checks++; if ({err_lk, err_rv} !== 2'b00) begin
            fails++; $display("FAIL short_drop: got %b want 00", {err_lk, err_rv}); end
        checks++; if (fs_n !== 4) begin fails++; $display("FAIL short_fs: got %0d want 4", fs_n); end
        checks++; if ({lock_fs[0], lock_fs[1], lock_fs[2], lock_fs[3]} !== 4'b1001) begin
            fails++; $display("FAIL short_relock_seq: got %b want 1001", {lock_fs[0], lock_fs[1], lock_fs[2], lock_fs[3]}); end
        checks++; if (locked !== 1'b1) begin fails++; $display("FAIL short_relocked: got %b want 1", locked); end
    endtask

    task automatic test_hs_stuck();
        clear_obs();
        for (int l = 0; l < 4; l++) send_line(l, VT);
        pix_n = 0;
        for (int k = 0; k < 1100; k++) pix(1'b1, 1'b1, 1'b0);
        checks++; if (err_n !== 1) begin fails++; $display("FAIL stuck_err: got %0d want 1", err_n); end
        checks++; if (err_pix !== 984) begin fails++; $display("FAIL stuck_err_at: got %0d want 984", err_pix); end
        checks++; if ({err_lk, err_rv, locked} !== 3'b000) begin
            fails++; $display("FAIL stuck_drop: got %b want 000", {err_lk, err_rv, locked}); end
    endtask

    task automatic test_short_frame();
        clear_obs();
        send_frame(VT, 0);
        send_frame(VT, 0);
        send_frame(VT - 1, 0);
        send_frame(VT, 0);
        checks++; if (err_n !== 1) begin fails++; $display("FAIL sframe_err: got %0d want 1", err_n); end
        checks++; if (err_fl !== 10'd11) begin fails++; $display("FAIL sframe_lines: got %0d want 11", err_fl); end
        checks++; if (fs_n !== 3) begin fails++; $display("FAIL sframe_fs: got %0d want 3", fs_n); end
        checks++; if ({lock_seen, locked} !== 2'b00) begin
            fails++; $display("FAIL sframe_nolock: got %b want 00", {lock_seen, locked}); end
        checks++; if (frame_lines !== 10'd11) begin fails++; $display("FAIL sframe_hold: got %0d want 11", frame_lines); end
    endtask

    task automatic test_blank();
        clear_obs();
        repeat (3) send_frame(VT, 0);
        checks++; if ({locked, err_n == 0} !== 2'b11) begin
            fails++; $display("FAIL blank_prelock: got locked=%b errs=%0d want 1,0", locked, err_n); end
        clear_obs();
        blank_l = VO + 2; blank_p = HO + 5;
        send_frame(VT, 0);
        blank_l = -1; blank_p = -1;
`ifdef VGA_SYNC_DEC_BLANK_CHECK_EN
        checks++; if (err_n !== 1) begin fails++; $display("FAIL blank_err: got %0d want 1", err_n); end
        checks++; if ({err_x, err_y} !== {10'd5, 10'd2}) begin
            fails++; $display("FAIL blank_err_xy: got %0d,%0d want 5,2", err_x, err_y); end
        checks++; if ({err_lk, locked} !== 2'b00) begin
            fails++; $display("FAIL blank_drop: got %b want 00", {err_lk, locked}); end
`else
        checks++; if (err_n !== 0) begin fails++; $display("FAIL blank_ignored: got %0d want 0", err_n); end
        checks++; if (locked !== 1'b1) begin fails++; $display("FAIL blank_keeplock: got %b want 1", locked); end
`endif
    endtask

    task automatic test_mid_reset();
        for (int l = 0; l < 5; l++) send_line(l, VT);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++; if ({locked, rx_valid, err, frame_start} !== 4'b0) begin
            fails++; $display("FAIL mreset_flags: got %b want 0000", {locked, rx_valid, err, frame_start}); end
        checks++; if ({rx_x, rx_y, line_len, frame_lines} !== 40'd0) begin
            fails++; $display("FAIL mreset_counts: got %h want 0", {rx_x, rx_y, line_len, frame_lines}); end
        @(negedge clk);
        rst_n = 1'b1;
        clear_obs();
        send_frame(VT, 6);
        send_frame(VT, 0);
        send_frame(VT, 0);
        checks++; if ({lock_seen, fs_n == 2} !== 2'b01) begin
            fails++; $display("FAIL mreset_early: got lock_seen=%b fs=%0d want 0,2", lock_seen, fs_n); end
        send_frame(VT, 0);
        checks++; if ({lock_fs[0], lock_fs[1], lock_fs[2]} !== 3'b001) begin
            fails++; $display("FAIL mreset_lock_seq: got %b want 001", {lock_fs[0], lock_fs[1], lock_fs[2]}); end
        checks++; if (locked !== 1'b1) begin fails++; $display("FAIL mreset_locked: got %b want 1", locked); end
    endtask

    initial begin
        clear_obs();
        test_reset();
        test_nominal();
        test_short_line();
        test_hs_stuck();
        test_short_frame();
        test_blank();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
